// File: rtl/store_writer.sv
// Store writer: formats core store requests into word-aligned, lane-shifted
// memory writes, buffers them in an in-order FIFO and drains them over a
// valid/ready port. Misaligned or illegal stores are consumed and flagged.

package store_writer_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_entry_t;

endpackage

module store_writer
    import store_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    input  logic [2:0]       req_f3,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty,
    output logic             err_valid,
    output logic [31:0]      err_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    st_entry_t        mem_q [DEPTH];
    st_entry_t        head_q;
    st_entry_t        head_nxt;
    st_entry_t        fmt_c;
    logic             fmt_err;
    logic [1:0]       off;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             ready_q;
    logic             valid_q;
    logic             empty_q;
    logic             err_valid_q;
    logic [31:0]      err_addr_q;
    logic             accept;
    logic             push;
    logic             pop;

    assign off    = req_addr[1:0];
    assign accept = req_valid && ready_q;
    assign push   = accept && !fmt_err;
    assign pop    = valid_q && mem_ready;

    // Request formatting: byte enables, lane shift and alignment check
    always_comb begin
        fmt_c      = '0;
        fmt_err    = 1'b0;
        fmt_c.addr = {req_addr[31:2], 2'b00};
        case (req_f3)
            3'b000: begin
                fmt_c.be    = 4'b0001 << off;
                fmt_c.wdata = {24'h0, req_data[7:0]} << {off, 3'b000};
            end
            3'b001: begin
                if (off[0]) begin
                    fmt_err = 1'b1;
                end else if (off[1]) begin
                    fmt_c.be    = 4'b1100;
                    fmt_c.wdata = {req_data[15:0], 16'h0};
                end else begin
                    fmt_c.be    = 4'b0011;
                    fmt_c.wdata = {16'h0, req_data[15:0]};
                end
            end
            3'b010: begin
                if (off != 2'b00) begin
                    fmt_err = 1'b1;
                end else begin
                    fmt_c.be    = 4'b1111;
                    fmt_c.wdata = req_data;
                end
            end
            default: fmt_err = 1'b1;
        endcase
    end

    // Next pointer/count and next head; a push into an otherwise empty FIFO bypasses storage
    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_nxt  = count_q + CNT_W'(push) - CNT_W'(pop);
        head_nxt   = '0;
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push && count_nxt == CNT_W'(1)) begin
            head_nxt = fmt_c;
        end else begin
            head_nxt = mem_q[rd_ptr_nxt];
        end
    end

    // Entry storage, written on push only
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fmt_c;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            empty_q     <= 1'b1;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q    <= rd_ptr_nxt;
            count_q     <= count_nxt;
            head_q      <= head_nxt;
            ready_q     <= (count_nxt < CNT_W'(DEPTH));
            valid_q     <= (count_nxt != '0);
            empty_q     <= (count_nxt == '0);
            err_valid_q <= accept && fmt_err;
            if (accept && fmt_err) begin
                err_addr_q <= req_addr;
            end
        end
    end

    assign req_ready = ready_q;
    assign mem_valid = valid_q;
    assign mem_addr  = head_q.addr;
    assign mem_wdata = head_q.wdata;
    assign mem_be    = head_q.be;
    assign occupancy = count_q;
    assign empty     = empty_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

endmodule

// File: doc/store_writer.md
Name: store_writer

Overview:
Store-side counterpart of the load-data formatting path. Accepts store requests (address, rs2 data, f3) from the core and converts each one into a word-aligned address, lane-shifted write data and a byte-enable mask. Buffers the result in a small in-order FIFO and drains it to the data-memory write port over a valid/ready handshake. Sits between the execute stage and the data memory / cache write port, and flags misaligned or illegal stores.

Parameters:
DEPTH, 4, number of buffered store entries; power of two, >= 2.
CNT_W, $clog2(DEPTH+1), width of the occupancy output (derived; not overridden).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  store request present.
req_ready  output  1  writer can accept a request this cycle.
req_addr  input  32  byte address of the store.
req_data  input  32  rs2 value; only low byte/half used for SB/SH.
req_f3  input  3  funct3: 000 SB, 001 SH, 010 SW; all others illegal.
mem_valid  output  1  head entry presented to memory.
mem_ready  input  1  memory accepts the head entry this cycle.
mem_addr  output  32  word address, req_addr with bits [1:0] forced to 0.
mem_wdata  output  32  lane-aligned write data.
mem_be  output  4  byte-enable mask, bit i enables bits [8i+7:8i].
occupancy  output  CNT_W  number of valid entries, 0..DEPTH.
empty  output  1  occupancy == 0; used by load ordering logic.
err_valid  output  1  one-cycle pulse: rejected store.
err_addr  output  32  req_addr of the most recent rejected store.

Behaviour:
- Reset (async assert, sync-safe release): FIFO pointers and occupancy cleared. All outputs go to these values: req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, occupancy=0, empty=1, err_valid=0, err_addr=0. In-flight entries are discarded, with no partial writes. A reset asserted during an active mem handshake drops mem_valid immediately.
- Accept: a request is accepted when req_valid && req_ready. req_ready = (occupancy < DEPTH). req_ready is combinational from registered state only; there is no same-cycle pass-through when full.
- Formatting, off = req_addr[1:0]:
  - SB: be = 4'b0001 << off; wdata = {24'b0, data[7:0]} << (8*off).
  - SH: off=0 gives be=0011, wdata={16'b0,data[15:0]}. off=2 gives be=1100, wdata=data[15:0]<<16. off=1 or 3 is misaligned.
  - SW: off=0 gives be=1111, wdata=data. Any other off is misaligned.
  - Lanes with be=0 are always driven 0.
- Error: a misaligned or illegal-f3 request is still accepted (handshake completes) but is NOT enqueued. err_valid pulses high the following cycle and err_addr loads req_addr on that edge. err_addr holds until the next error.
- Enqueue latency: a request accepted in cycle N becomes visible at the head no earlier than N+1. mem_valid rises in N+1 if the FIFO was empty.
- Drain: the head pops on mem_valid && mem_ready. mem_addr, mem_wdata and mem_be are registered FIFO head outputs and stay stable while mem_valid=1 and mem_ready=0. Stores drain strictly in acceptance order.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Full: with occupancy == DEPTH, req_ready=0 and req_valid is ignored. A pop frees a slot and req_ready=1 from the next cycle.
- Empty: mem_valid=0 and mem_ready is ignored.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Occupancy is a separate counter, never exceeds DEPTH and never underflows.

Test Plan:
- SB with data=0x000000A5 at addr 0x100..0x103, mem_ready=1 → four writes to mem_addr=0x100 with be 0001/0010/0100/1000 and wdata 0xA5, 0xA500, 0xA50000, 0xA5000000.
- SH with data=0xDEADBEEF at addr 0x202 → mem_addr=0x200, be=1100, wdata=0xBEEF0000. SW at 0x300 with 0x12345678 → be=1111, wdata=0x12345678.
- SW at 0x301, then SH at 0x403, then f3=011 → nothing reaches memory. err_valid pulses 3 times, and err_addr reads 0x301, 0x403, then that request's address.
- mem_ready=0, push 5 SW with DEPTH=4 → req_ready=0 after 4, occupancy=4, head stable. Release mem_ready → 4 writes in order, then the 5th is accepted and written.
- Continuous req_valid and mem_ready=1 with one entry resident → push and pop in the same cycle, occupancy stays 1, one write per cycle, no drops.
- Three entries queued with mem_ready=0, then rst_n pulsed low mid-cycle → outputs reset asynchronously, occupancy=0, empty=1, and no further mem_valid after release.
